// File: rtl/tmul_frame_multi_pkg.sv
// Shared types and helpers for the temporal-coded stochastic multiplier.
package tmul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int frame_len(input int width);
        return 1 << width;
    endfunction

    // Reverses the low `width` bits of v; the upper bits of the result are zero.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int width);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            r[i] = v[width-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/tmul_frame_multi_if.sv
// Operand/result bundle of the multiplier; the slave side is the multiplier.
// Handshake: load is sampled on every rising edge and always wins; ready is high only
// in IDLE, busy only in RUN, and done pulses for one cycle as res updates.
interface tmul_frame_multi_if
    import tmul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic [WIDTH-1:0]             iA;
    logic [LANES*WIDTH-1:0]       iB;
    logic                         bipolar;
    logic                         load;
    logic                         ready;
    logic                         busy;
    logic                         active;
    logic [LANES-1:0]             oC;
    logic                         done;
    logic [LANES*(WIDTH+1)-1:0]   res;
    state_t                       dbg_state;

    modport master (
        output iA, iB, bipolar, load,
        input  ready, busy, active, oC, done, res, dbg_state
    );

    modport slave (
        input  iA, iB, bipolar, load,
        output ready, busy, active, oC, done, res, dbg_state
    );
endinterface

// File: rtl/tmul_frame_multi_vdc_rng.sv
// Van der Corput sequence: frame index k and its bit-reversal, with a terminal flag.
module vdc_rng
    import tmul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] seq,
    output logic             last
);
    localparam int FRAME_LEN = frame_len(WIDTH);

    logic [WIDTH-1:0] k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k <= '0;
        end else if (clear) begin
            k <= '0;
        end else if (enable) begin
            k <= k + 1'b1;
        end
    end

    assign seq  = WIDTH'(bit_rev(32'(k), WIDTH));
    assign last = (k == WIDTH'(FRAME_LEN - 1));
endmodule

// File: rtl/tmul_frame_multi.sv
// Multi-lane stochastic multiplier: shared run-length A, per-lane B vs. shared VdC sequence,
// per-lane ones counting over a 2^WIDTH-cycle frame.
module tmul_frame_multi
    import tmul_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    tmul_frame_multi_if.slave    bus
);
    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_cnt;
    logic [LANES*WIDTH-1:0] bbuf;
    logic                 mode;
    logic                 done_q;
    logic                 busy;
    logic                 active;
    logic                 last;
    logic [WIDTH-1:0]     rng;
    logic [LANES-1:0]     oc;
    logic [WIDTH:0]       ones     [LANES];
    logic [WIDTH:0]       res_lane [LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load always restarts the frame, even on its final cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (bus.load) state_next = RUN;
            RUN: begin
                if (bus.load)  state_next = RUN;
                else if (last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy   = (state == RUN);
    assign active = busy && (a_cnt != '0);

    vdc_rng #(.WIDTH(WIDTH)) u_rng (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.load),
        .enable (busy && !bus.load),
        .seq    (rng),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_cnt  <= '0;
            bbuf   <= '0;
            mode   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                a_cnt <= bus.iA;
                bbuf  <= bus.iB;
                mode  <= bus.bipolar;
            end else if (busy) begin
                if (a_cnt != '0) a_cnt <= a_cnt - 1'b1;
                if (last)        done_q <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic cmp;
        assign cmp   = (bbuf[i*WIDTH +: WIDTH] > rng);
        assign oc[i] = busy & (mode ? ~(active ^ cmp) : (active & cmp));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ones[i]     <= '0;
                res_lane[i] <= '0;
            end else if (bus.load) begin
                ones[i] <= '0;
            end else if (busy) begin
                ones[i] <= ones[i] + (WIDTH+1)'(oc[i]);
                if (last) res_lane[i] <= ones[i] + (WIDTH+1)'(oc[i]);
            end
        end

        assign bus.res[i*(WIDTH+1) +: (WIDTH+1)] = res_lane[i];
    end

    assign bus.ready     = (state == IDLE);
    assign bus.busy      = busy;
    assign bus.active    = active;
    assign bus.oC        = oc;
    assign bus.done      = done_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_tmul_frame_multi.sv
// Directed bench for tmul_frame_multi (WIDTH=8, LANES=4) with hand-computed expectations.
module tb_tmul_frame_multi;
    localparam int WIDTH = 8;
    localparam int LANES = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    tmul_frame_multi_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    tmul_frame_multi #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pack_b(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [35:0] pack_r(input logic [8:0] r0, r1, r2, r3);
        return {r3, r2, r1, r0};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of the first RUN cycle (k=0).
    task automatic launch(input logic [7:0] a, input logic [31:0] b, input logic bip);
        bus.iA      = a;
        bus.iB      = b;
        bus.bipolar = bip;
        bus.load    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.load    = 1'b0;
    endtask

    // edges counts rising edges since load was driven, including the capture edge.
    task automatic wait_done(output int edges, output int act_cnt);
        edges   = 1;
        act_cnt = 0;
        while (!bus.done && edges < 400) begin
            if (bus.active) act_cnt++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    // Advances n cycles, reporting whether done was seen high on any of them.
    task automatic run_cycles(input int n, output logic saw_done);
        saw_done = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        int   act;
        logic saw;

        bus.iA      = '0;
        bus.iB      = '0;
        bus.bipolar = 1'b0;
        bus.load    = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_ready",  64'(bus.ready),  64'd1);
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_oc",     64'(bus.oC),     64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_res",    64'(bus.res),    64'd0);
        check("rst_active", 64'(bus.active), 64'd0);

        // Unipolar 128*128: active for k=0..127, cmp when k is even.
        launch(8'd128, pack_b(128, 128, 128, 128), 1'b0);
        check("t1_busy",  64'(bus.busy),  64'd1);
        check("t1_ready", 64'(bus.ready), 64'd0);
        wait_done(lat, act);
        check("t1_lat", 64'(lat), 64'd257);
        check("t1_act", 64'(act), 64'd128);
        check("t1_res", 64'(bus.res), 64'(pack_r(64, 64, 64, 64)));
        @(negedge clk);
        check("t1_done_pulse", 64'(bus.done),  64'd0);
        check("t1_ready_end",  64'(bus.ready), 64'd1);

        launch(8'd0, pack_b(0, 255, 128, 1), 1'b0);
        wait_done(lat, act);
        check("t2_act", 64'(act), 64'd0);
        check("t2_res", 64'(bus.res), 64'(pack_r(0, 0, 0, 0)));

        launch(8'd128, pack_b(0, 255, 128, 1), 1'b0);
        wait_done(lat, act);
        check("t3_res", 64'(bus.res), 64'(pack_r(0, 128, 64, 1)));

        // a_cnt is nonzero for k=0..254 and rng<255 on all of those cycles.
        launch(8'd255, pack_b(255, 255, 255, 255), 1'b0);
        wait_done(lat, act);
        check("t4_res", 64'(bus.res), 64'(pack_r(255, 255, 255, 255)));

        launch(8'd255, pack_b(255, 255, 255, 255), 1'b1);
        wait_done(lat, act);
        check("t5a_res", 64'(bus.res), 64'(pack_r(256, 256, 256, 256)));
        launch(8'd0, pack_b(0, 0, 0, 0), 1'b1);
        wait_done(lat, act);
        check("t5b_res", 64'(bus.res), 64'(pack_r(256, 256, 256, 256)));
        launch(8'd255, pack_b(0, 0, 0, 0), 1'b1);
        wait_done(lat, act);
        check("t5c_res", 64'(bus.res), 64'(pack_r(1, 1, 1, 1)));

        // Abort at k=100.
        launch(8'd128, pack_b(128, 128, 128, 128), 1'b0);
        run_cycles(100, saw);
        launch(8'd255, pack_b(255, 255, 255, 255), 1'b1);
        check("t6_no_done", 64'(saw || bus.done), 64'd0);
        check("t6_res_held", 64'(bus.res), 64'(pack_r(1, 1, 1, 1)));
        wait_done(lat, act);
        check("t6_lat", 64'(lat), 64'd257);
        check("t6_res", 64'(bus.res), 64'(pack_r(256, 256, 256, 256)));

        // Load in the final cycle (k=255).
        launch(8'd128, pack_b(128, 128, 128, 128), 1'b0);
        run_cycles(255, saw);
        launch(8'd0, pack_b(0, 255, 128, 1), 1'b0);
        check("t7_no_done", 64'(saw || bus.done), 64'd0);
        check("t7_busy",    64'(bus.busy), 64'd1);
        check("t7_res_held", 64'(bus.res), 64'(pack_r(256, 256, 256, 256)));
        wait_done(lat, act);
        check("t7_lat", 64'(lat), 64'd257);
        check("t7_res", 64'(bus.res), 64'(pack_r(0, 0, 0, 0)));

        // Back-to-back: load in the done cycle.
        check("t8_ready_idle", 64'(bus.ready), 64'd1);
        check("t8_busy_idle",  64'(bus.busy),  64'd0);
        launch(8'd128, pack_b(0, 255, 128, 1), 1'b0);
        check("t8_ready_run", 64'(bus.ready), 64'd0);
        check("t8_busy_run",  64'(bus.busy),  64'd1);
        wait_done(lat, act);
        check("t8a_lat", 64'(lat), 64'd257);
        check("t8a_res", 64'(bus.res), 64'(pack_r(0, 128, 64, 1)));
        launch(8'd128, pack_b(128, 128, 128, 128), 1'b0);
        wait_done(lat, act);
        check("t8b_lat", 64'(lat), 64'd257);
        check("t8b_res", 64'(bus.res), 64'(pack_r(64, 64, 64, 64)));

        // Reset mid-frame.
        launch(8'd255, pack_b(255, 255, 255, 255), 1'b1);
        run_cycles(50, saw);
        rst = 1'b1;
        #1;
        check("t9_ready",  64'(bus.ready),  64'd1);
        check("t9_busy",   64'(bus.busy),   64'd0);
        check("t9_oc",     64'(bus.oC),     64'd0);
        check("t9_done",   64'(bus.done),   64'd0);
        check("t9_res",    64'(bus.res),    64'd0);
        check("t9_active", 64'(bus.active), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
